// File: rtl/debug_trace_pkg.sv
// debug_trace_pkg: header constants, enums and beat formatting shared by the STM ATB source
package debug_trace_pkg;

    localparam logic [7:0]  HDR_DATA  = 8'h10;
    localparam logic [7:0]  HDR_OVFL  = 8'h20;
    localparam logic [63:0] SYNC_WORD = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {SZ_1B, SZ_2B, SZ_4B, SZ_4B_ALT} size_e;
    typedef enum logic [1:0] {BT_NONE, BT_DATA, BT_OVFL, BT_SYNC} beat_e;
    typedef enum logic [2:0] {ST_OFF, ST_RUN, ST_FLUSH, ST_ACK, ST_DRAIN} state_e;

    typedef struct packed {
        logic [7:0]  channel;
        size_e       size;
        logic [31:0] data;
    } stim_t;

    function automatic size_e norm_size(input size_e s);
        return (s == SZ_4B_ALT) ? SZ_4B : s;
    endfunction

    function automatic logic [63:0] data_word(input stim_t s);
        logic [31:0] p;
        p = (s.size == SZ_1B) ? {24'b0, s.data[7:0]} :
            (s.size == SZ_2B) ? {16'b0, s.data[15:0]} : s.data;
        return {16'b0, p, s.channel, HDR_DATA | {6'b0, norm_size(s.size)}};
    endfunction

    // valid bytes minus one: two header bytes plus payload
    function automatic logic [2:0] data_bytes(input size_e s);
        return (s == SZ_1B) ? 3'd2 : (s == SZ_2B) ? 3'd3 : 3'd5;
    endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// trace_sync_fifo: first-word-fall-through stimulus FIFO with full/empty flags
module trace_sync_fifo
    import debug_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  i_push,
    input  stim_t i_wdata,
    input  logic  i_pop,
    output stim_t o_rdata,
    output logic  o_full,
    output logic  o_empty
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    stim_t       r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + ONE;
            if (i_pop) r_rptr <= r_rptr + ONE;
        end
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

endmodule

// File: rtl/stm_atb_source.sv
// stm_atb_source: queues stimulus writes and emits single-beat DATA/OVFL/SYNC packets on ATB
module stm_atb_source
    import debug_trace_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int ATID_WIDTH  = 8,
    parameter int SYNC_PERIOD = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [ATID_WIDTH-1:0] trace_id_i,
    input  logic                  stim_valid_i,
    input  logic [7:0]            stim_channel_i,
    input  logic [1:0]            stim_size_i,
    input  logic [31:0]           stim_data_i,
    output logic                  atvalid_o,
    input  logic                  atready_i,
    output logic [ATID_WIDTH-1:0] atid_o,
    output logic [63:0]           atdata_o,
    output logic [2:0]            atbytes_o,
    input  logic                  afvalid_i,
    output logic                  afready_o,
    output logic                  busy_o
);

    state_e                r_state;
    state_e                w_state_nxt;
    beat_e                 r_type;
    beat_e                 w_sel;
    stim_t                 w_stim;
    stim_t                 w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_en_rise;
    logic                  w_data_hs;
    logic                  w_sync_hit;
    logic                  w_can_load;
    logic                  w_load;
    logic                  w_sync_ld;
    logic                  w_ovfl_ld;
    logic                  w_idle_out;
    logic                  r_en_q;
    logic                  r_sync_pend;
    logic                  r_ovfl_pend;
    logic                  r_atvalid;
    logic [7:0]            r_drop_cnt;
    logic [31:0]           r_beat_cnt;
    logic [63:0]           r_atdata;
    logic [63:0]           w_beat_data;
    logic [2:0]            r_atbytes;
    logic [2:0]            w_beat_bytes;
    logic [ATID_WIDTH-1:0] r_atid;

    assign w_stim     = '{channel: stim_channel_i, size: size_e'(stim_size_i), data: stim_data_i};
    assign w_wr       = stim_valid_i & enable_i & (r_state != ST_FLUSH);
    assign w_push     = w_wr & ~w_full;
    assign w_drop     = w_wr & w_full;
    assign w_en_rise  = enable_i & ~r_en_q;
    assign w_data_hs  = r_atvalid & atready_i & (r_type == BT_DATA);
    // the beat that completes a period hands over to SYNC on the same edge
    assign w_sync_hit = (SYNC_PERIOD != 0) && w_data_hs && ((r_beat_cnt + 32'd1) == 32'(SYNC_PERIOD));
    assign w_can_load = ~r_atvalid | atready_i;
    assign w_sel      = ((r_sync_pend | w_sync_hit) && r_state == ST_RUN && enable_i) ? BT_SYNC :
                        r_ovfl_pend ? BT_OVFL : !w_empty ? BT_DATA : BT_NONE;
    assign w_load     = w_can_load & (w_sel != BT_NONE);
    assign w_sync_ld  = w_load & (w_sel == BT_SYNC);
    assign w_ovfl_ld  = w_load & (w_sel == BT_OVFL);
    assign w_idle_out = w_empty & ~r_ovfl_pend & ~r_atvalid;

    assign w_beat_data  = (w_sel == BT_SYNC) ? SYNC_WORD :
                          (w_sel == BT_OVFL) ? {48'b0, r_drop_cnt, HDR_OVFL} : data_word(w_head);
    assign w_beat_bytes = (w_sel == BT_SYNC) ? 3'd7 :
                          (w_sel == BT_OVFL) ? 3'd1 : data_bytes(w_head.size);

    trace_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_wdata (w_stim),
        .i_pop   (w_load && w_sel == BT_DATA),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:   w_state_nxt = afvalid_i ? ST_ACK : enable_i ? ST_RUN : ST_OFF;
            ST_RUN:   w_state_nxt = !enable_i ? ST_DRAIN : afvalid_i ? ST_FLUSH : ST_RUN;
            ST_FLUSH: w_state_nxt = w_idle_out ? ST_ACK : ST_FLUSH;
            ST_ACK:   w_state_nxt = enable_i ? ST_RUN : ST_OFF;
            ST_DRAIN: w_state_nxt = w_idle_out ? ST_OFF : ST_DRAIN;
            default:  w_state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_OFF;
            r_en_q      <= 1'b0;
            r_sync_pend <= 1'b0;
            r_ovfl_pend <= 1'b0;
            r_drop_cnt  <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_en_q      <= enable_i;
            r_sync_pend <= w_en_rise | (enable_i & ~w_sync_ld & (r_sync_pend | w_sync_hit));
            r_ovfl_pend <= w_ovfl_ld ? w_drop : (r_ovfl_pend | w_drop);
            r_drop_cnt  <= w_ovfl_ld ? {7'b0, w_drop} :
                           (w_drop && r_drop_cnt != 8'hFF) ? r_drop_cnt + 8'd1 : r_drop_cnt;
            r_beat_cnt  <= w_sync_ld ? '0 : w_data_hs ? r_beat_cnt + 32'd1 : r_beat_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_atvalid <= 1'b0;
            r_type    <= BT_NONE;
            r_atdata  <= '0;
            r_atbytes <= '0;
            r_atid    <= '0;
        end else if (w_can_load) begin
            r_atvalid <= w_load;
            if (w_load) begin
                r_type    <= w_sel;
                r_atdata  <= w_beat_data;
                r_atbytes <= w_beat_bytes;
                r_atid    <= trace_id_i;
            end
        end
    end

    assign atvalid_o = r_atvalid;
    assign atdata_o  = r_atdata;
    assign atbytes_o = r_atbytes;
    assign atid_o    = r_atid;
    assign afready_o = (r_state == ST_ACK);
    assign busy_o    = ~w_empty | r_atvalid | r_sync_pend | r_ovfl_pend;

endmodule

// File: tb/tb_stm_atb_source.sv
// tb_stm_atb_source: scoreboard bench for the STM ATB source (default and short SYNC period)
module tb_stm_atb_source;

    typedef struct {
        logic [63:0] d;
        logic [2:0]  b;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en;
    logic        en4;
    logic        sv;
    logic        rdy;
    logic        rdy4;
    logic        afv;
    logic [7:0]  tid;
    logic [7:0]  sch;
    logic [1:0]  ssz;
    logic [31:0] sdat;
    logic        atv;
    logic        afr;
    logic        busy;
    logic [7:0]  atid;
    logic [63:0] atd;
    logic [2:0]  atb;
    logic        atv4;
    logic        afr4;
    logic        busy4;
    logic [7:0]  atid4;
    logic [63:0] atd4;
    logic [2:0]  atb4;
    beat_t       sb[$];
    beat_t       sb4[$];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk_i = ~clk_i;

    stm_atb_source dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(en), .trace_id_i(tid),
        .stim_valid_i(sv), .stim_channel_i(sch), .stim_size_i(ssz), .stim_data_i(sdat),
        .atvalid_o(atv), .atready_i(rdy), .atid_o(atid), .atdata_o(atd), .atbytes_o(atb),
        .afvalid_i(afv), .afready_o(afr), .busy_o(busy)
    );

    stm_atb_source #(.SYNC_PERIOD(4)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(en4), .trace_id_i(tid),
        .stim_valid_i(sv), .stim_channel_i(sch), .stim_size_i(ssz), .stim_data_i(sdat),
        .atvalid_o(atv4), .atready_i(rdy4), .atid_o(atid4), .atdata_o(atd4), .atbytes_o(atb4),
        .afvalid_i(afv), .afready_o(afr4), .busy_o(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic beat_t mk(input logic [63:0] d, input logic [2:0] b);
        beat_t r;
        r.d = d;
        r.b = b;
        return r;
    endfunction

    function automatic beat_t dbeat(input logic [7:0] ch, input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    return mk({40'b0, d[7:0], ch, 8'h10}, 3'd2);
            2'd1:    return mk({32'b0, d[15:0], ch, 8'h11}, 3'd3);
            default: return mk({16'b0, d, ch, 8'h12}, 3'd5);
        endcase
    endfunction

    always @(negedge clk_i) begin : mon
        beat_t e;
        if (rst_ni && atv && rdy) begin
            chk("sb_pending", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_data", atd, e.d);
                chk("beat_bytes", atb, e.b);
                chk("beat_id", atid, tid);
            end
        end
    end

    always @(negedge clk_i) begin : mon4
        beat_t e;
        if (rst_ni && atv4 && rdy4) begin
            chk("sb4_pending", sb4.size() != 0, 1'b1);
            if (sb4.size() != 0) begin
                e = sb4.pop_front();
                chk("beat4_data", atd4, e.d);
                chk("beat4_bytes", atb4, e.b);
                chk("beat4_id", atid4, tid);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [7:0] ch, input logic [1:0] sz, input logic [31:0] d);
        sv = 1'b1;
        sch = ch;
        ssz = sz;
        sdat = d;
        tick();
        sv = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && (sb.size() != 0 || sb4.size() != 0 || atv || atv4); i++) tick();
        chk({tag, "_drained"}, 64'(sb.size() + sb4.size()), 64'd0);
    endtask

    initial begin
        rst_ni = 1'b0; en = 1'b0; en4 = 1'b0; sv = 1'b0; rdy = 1'b0; rdy4 = 1'b0; afv = 1'b0;
        tid = 8'h5A; sch = '0; ssz = '0; sdat = '0;
        repeat (3) tick();
        chk("rst_atvalid", atv, 0);
        chk("rst_afready", afr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_atdata", atd, 0);
        chk("rst_atbytes", atb, 0);
        chk("rst_atid", atid, 0);
        rst_ni = 1'b1;
        tick();

        sb.push_back(mk(64'h8000_0000_0000_0000, 3'd7));
        rdy = 1'b1;
        en = 1'b1;
        drain("first_sync");

        sb.push_back(mk(64'h0000_DEAD_BEEF_0512, 3'd5));
        wr(8'h05, 2'd2, 32'hDEADBEEF);
        @(negedge clk_i) chk("latency_t1", atv, 0);
        @(negedge clk_i) chk("latency_t2", atv, 1);
        drain("latency");

        rdy = 1'b0;
        sb.push_back(dbeat(8'hA1, 2'd0, 32'h1234_5677));
        wr(8'hA1, 2'd0, 32'h1234_5677);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("stall_valid", atv, 1);
            chk("stall_data", atd, 64'h0000_0000_0077_A110);
            chk("stall_bytes", atb, 3'd2);
            chk("stall_id", atid, 8'h5A);
            chk("stall_busy", busy, 1);
        end
        tick();
        rdy = 1'b1;
        drain("stall");

        rdy = 1'b0;
        sb.push_back(dbeat(8'h40, 2'd1, 32'h1000));
        sb.push_back(mk(64'h0320, 3'd1));
        for (int i = 1; i < 17; i++) sb.push_back(dbeat(8'(8'h40 + i), 2'd1, 32'h1000 + i));
        for (int i = 0; i < 20; i++) wr(8'(8'h40 + i), 2'd1, 32'h1000 + i);
        tick();
        chk("ovfl_busy", busy, 1);
        rdy = 1'b1;
        drain("ovfl");
        chk("idle_busy", busy, 0);

        rdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sb.push_back(dbeat(8'(8'h60 + i), 2'd0, 32'hC0 + i));
            wr(8'(8'h60 + i), 2'd0, 32'hC0 + i);
        end
        afv = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) wr(8'(8'h70 + i), 2'd2, 32'h5555_0000 + i);
        rdy = 1'b1;
        for (int k = 0; k < 200 && afr !== 1'b1; k++) @(negedge clk_i);
        chk("flush_ack", afr, 1);
        chk("flush_sb_left", 64'(sb.size()), 0);
        chk("flush_atvalid", atv, 0);
        tick();
        afv = 1'b0;
        @(negedge clk_i) chk("ack_pulse", afr, 0);
        tick();
        sb.push_back(dbeat(8'h7F, 2'd2, 32'hCAFE_F00D));
        wr(8'h7F, 2'd2, 32'hCAFE_F00D);
        drain("post_flush");

        en = 1'b0;
        repeat (3) tick();
        sb4.push_back(mk(64'h8000_0000_0000_0000, 3'd7));
        for (int i = 0; i < 9; i++) begin
            sb4.push_back(dbeat(8'(8'h80 + i), 2'd0, 32'(i)));
            if (i == 3 || i == 7) sb4.push_back(mk(64'h8000_0000_0000_0000, 3'd7));
        end
        en4 = 1'b1;
        rdy4 = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 9; i++) wr(8'(8'h80 + i), 2'd0, 32'(i));
        drain("period");

        rdy4 = 1'b0;
        wr(8'h99, 2'd0, 32'h1);
        tick();
        chk("pre_rst_valid", atv4, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", atv4, 0);
        chk("async_rst_data", atd4, 0);
        chk("async_rst_busy", busy4, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
